mc_port_arbiter: RTL and testbench

Shares one Convey memory-controller (MC) port between NUM_REQ personality-side requesters. Requests are granted round-robin and issued through a registered request stage that obeys `mc_rq_stall`. The requester ID is placed in the upper bits of `mc_rq_rtnctl` so each response can be routed back to its requester. The block sits between the user accelerators and one MC port slice of the Wolverine platform wrapper, and also reports port idleness from an outstanding-request count.

---
 rtl/mc_arb_pkg.sv | 33 +++
 rtl/mc_port_arbiter_rr_arbiter.sv | 61 ++++++
 rtl/mc_port_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_mc_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_arb_pkg.sv
// Shared definitions for the MC port arbiter.
// Holds the MC request/response field widths, the MC command encodings and
// the packed request-field record used by the registered request stage.
package mc_arb_pkg;

  localparam int VADR_W = 48;
  localparam int DATA_W = 64;
  localparam int CMD_W  = 3;
  localparam int SCMD_W = 4;
  localparam int SIZE_W = 2;

  // MC command codes. The arbiter forwards commands unchanged; the codes are
  // kept here so requesters and the bench share one definition.
  typedef enum logic [CMD_W-1:0] {
    MC_CMD_IDLE   = 3'd0,
    MC_CMD_RD     = 3'd1,
    MC_CMD_WR     = 3'd2,
    MC_CMD_ATOMIC = 3'd3,
    MC_CMD_RDFL   = 3'd6,
    MC_CMD_WRCMP  = 3'd7
  } mc_cmd_e;

  // Request fields captured by the output register (rtnctl is held
  // separately because its width is a module parameter).
  typedef struct packed {
    logic [VADR_W-1:0] vadr;
    logic [DATA_W-1:0] data;
    logic [SIZE_W-1:0] size;
    logic [CMD_W-1:0]  cmd;
    logic [SCMD_W-1:0] scmd;
  } mc_rq_fields_t;

endpackage

// File: rtl/mc_port_arbiter_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, i_reset_n : clock, asynchronous active-low reset
//   req            : per-requester request
//   en             : grant enable; with en=0 no grant is made and ptr holds
//   grant          : one-hot (or zero) grant, combinational from req/ptr/en
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               i_reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] win_idx;
  logic             found;

  // Scan from ptr upward, wrapping modulo NUM_REQ; first asserted req wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    found   = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr_reg) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (en && found) begin
      grant[win_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (en && found) begin
      ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/mc_port_arbiter.sv
// Shares one Convey MC port between NUM_REQ requesters.
// Ports:
//   clk, i_reset_n           : clock, asynchronous active-low reset
//   req_* / req_rdy          : requester-side request bus; req_rdy is the
//                              combinational one-hot grant (transfer this cycle)
//   rs_vld / rs_* / rs_stall : response routed by requester ID, fields broadcast
//   mc_rq_* / mc_rq_stall    : registered MC request stage
//   mc_rs_* / mc_rs_stall    : MC response input and registered backpressure
//   port_idle                : registered, high when nothing is outstanding
// The requester ID rides in the top ID_W bits of mc_rq_rtnctl and is stripped
// from rs_rtnctl on the way back.
module mc_port_arbiter
  import mc_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int RTNCTL_WIDTH = 32,
  parameter int ID_W         = 2,
  parameter int MAX_OUT      = 64,
  parameter int CNT_W        = 7
) (
  input  logic                                    clk,
  input  logic                                    i_reset_n,
  input  logic [NUM_REQ-1:0]                      req_vld,
  output logic [NUM_REQ-1:0]                      req_rdy,
  input  logic [NUM_REQ*VADR_W-1:0]               req_vadr,
  input  logic [NUM_REQ*DATA_W-1:0]               req_data,
  input  logic [NUM_REQ*SIZE_W-1:0]               req_size,
  input  logic [NUM_REQ*CMD_W-1:0]                req_cmd,
  input  logic [NUM_REQ*SCMD_W-1:0]               req_scmd,
  input  logic [NUM_REQ*(RTNCTL_WIDTH-ID_W)-1:0]  req_rtnctl,
  output logic [NUM_REQ-1:0]                      rs_vld,
  output logic [CMD_W-1:0]                        rs_cmd,
  output logic [SCMD_W-1:0]                       rs_scmd,
  output logic [DATA_W-1:0]                       rs_data,
  output logic [RTNCTL_WIDTH-ID_W-1:0]            rs_rtnctl,
  input  logic [NUM_REQ-1:0]                      rs_stall,
  output logic                                    mc_rq_vld,
  output logic [RTNCTL_WIDTH-1:0]                 mc_rq_rtnctl,
  output logic [DATA_W-1:0]                       mc_rq_data,
  output logic [VADR_W-1:0]                       mc_rq_vadr,
  output logic [SIZE_W-1:0]                       mc_rq_size,
  output logic [CMD_W-1:0]                        mc_rq_cmd,
  output logic [SCMD_W-1:0]                       mc_rq_scmd,
  input  logic                                    mc_rq_stall,
  input  logic                                    mc_rs_vld,
  input  logic [CMD_W-1:0]                        mc_rs_cmd,
  input  logic [SCMD_W-1:0]                       mc_rs_scmd,
  input  logic [DATA_W-1:0]                       mc_rs_data,
  input  logic [RTNCTL_WIDTH-1:0]                 mc_rs_rtnctl,
  output logic                                    mc_rs_stall,
  output logic                                    port_idle
);

  localparam int TAG_W = RTNCTL_WIDTH - ID_W;

  // Per-requester views of the flattened request buses.
  logic [VADR_W-1:0] vadr_a [NUM_REQ];
  logic [DATA_W-1:0] data_a [NUM_REQ];
  logic [SIZE_W-1:0] size_a [NUM_REQ];
  logic [CMD_W-1:0]  cmd_a  [NUM_REQ];
  logic [SCMD_W-1:0] scmd_a [NUM_REQ];
  logic [TAG_W-1:0]  tag_a  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign vadr_a[gi] = req_vadr[gi*VADR_W +: VADR_W];
      assign data_a[gi] = req_data[gi*DATA_W +: DATA_W];
      assign size_a[gi] = req_size[gi*SIZE_W +: SIZE_W];
      assign cmd_a[gi]  = req_cmd[gi*CMD_W +: CMD_W];
      assign scmd_a[gi] = req_scmd[gi*SCMD_W +: SCMD_W];
      assign tag_a[gi]  = req_rtnctl[gi*TAG_W +: TAG_W];
    end
  endgenerate

  // ---------------------------------------------------------------- grant
  logic [CNT_W-1:0]   out_cnt_reg;
  logic [CNT_W-1:0]   out_cnt_next;
  logic               issue_ok;
  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic               granted;

  assign issue_ok = !mc_rq_stall && (out_cnt_reg < CNT_W'(MAX_OUT));
  // Gating with the reset keeps req_rdy low while reset is held, so no
  // requester believes a transfer happened into a register being cleared.
  assign arb_en   = issue_ok && i_reset_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .req       (req_vld),
    .en        (arb_en),
    .grant     (grant)
  );

  assign req_rdy = grant;
  assign granted = |grant;

  // Select the granted requester's fields (grant is one-hot or zero).
  mc_rq_fields_t     sel_fields;
  logic [TAG_W-1:0]  sel_tag;
  logic [ID_W-1:0]   sel_id;

  always_comb begin
    sel_fields = '0;
    sel_tag    = '0;
    sel_id     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_fields.vadr = vadr_a[i];
        sel_fields.data = data_a[i];
        sel_fields.size = size_a[i];
        sel_fields.cmd  = cmd_a[i];
        sel_fields.scmd = scmd_a[i];
        sel_tag         = tag_a[i];
        sel_id          = ID_W'(i);
      end
    end
  end

  // ------------------------------------------------------------- response
  logic [ID_W-1:0]    rs_id;
  logic               id_ok;
  logic [NUM_REQ-1:0] rs_vld_next;

  assign rs_id = mc_rs_rtnctl[RTNCTL_WIDTH-1 -: ID_W];

  // When NUM_REQ fills the ID space every ID is legal.
  generate
    if (NUM_REQ == (1 << ID_W)) begin : g_id_full
      assign id_ok = 1'b1;
    end else begin : g_id_part
      assign id_ok = (rs_id < ID_W'(NUM_REQ));
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rs_decode
      assign rs_vld_next[gi] = mc_rs_vld && id_ok && (rs_id == ID_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------- outstanding count
  logic underflow_evt;

  always_comb begin
    out_cnt_next  = out_cnt_reg;
    underflow_evt = mc_rs_vld && (out_cnt_reg == '0);
    if (granted && !mc_rs_vld) begin
      out_cnt_next = out_cnt_reg + 1'b1;
    end else if (!granted && mc_rs_vld && (out_cnt_reg != '0)) begin
      out_cnt_next = out_cnt_reg - 1'b1;
    end
  end

  // ------------------------------------------------------------ registers
  mc_rq_fields_t           rq_fields_reg;
  logic                    rq_vld_reg;
  logic [RTNCTL_WIDTH-1:0] rq_rtnctl_reg;
  logic [NUM_REQ-1:0]      rs_vld_reg;
  logic [CMD_W-1:0]        rs_cmd_reg;
  logic [SCMD_W-1:0]       rs_scmd_reg;
  logic [DATA_W-1:0]       rs_data_reg;
  logic [TAG_W-1:0]        rs_tag_reg;
  logic                    mc_rs_stall_reg;
  logic                    port_idle_reg;
  logic                    err_underflow;
  logic                    err_bad_id;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rq_vld_reg      <= 1'b0;
      rq_fields_reg   <= '0;
      rq_rtnctl_reg   <= '0;
      rs_vld_reg      <= '0;
      rs_cmd_reg      <= '0;
      rs_scmd_reg     <= '0;
      rs_data_reg     <= '0;
      rs_tag_reg      <= '0;
      mc_rs_stall_reg <= 1'b0;
      port_idle_reg   <= 1'b1;
      out_cnt_reg     <= '0;
      err_underflow   <= 1'b0;
      err_bad_id      <= 1'b0;
    end else begin
      rq_vld_reg <= granted;
      if (granted) begin
        rq_fields_reg <= sel_fields;
        rq_rtnctl_reg <= {sel_id, sel_tag};
      end
      rs_vld_reg <= rs_vld_next;
      if (mc_rs_vld) begin
        rs_cmd_reg  <= mc_rs_cmd;
        rs_scmd_reg <= mc_rs_scmd;
        rs_data_reg <= mc_rs_data;
        rs_tag_reg  <= mc_rs_rtnctl[TAG_W-1:0];
      end
      mc_rs_stall_reg <= |rs_stall;
      out_cnt_reg     <= out_cnt_next;
      // Computed from next-state values so port_idle tracks the cycle in
      // which mc_rq_vld and the count are actually presented.
      port_idle_reg   <= (out_cnt_next == '0) && !granted;
      if (underflow_evt) begin
        err_underflow <= 1'b1;
      end
      if (mc_rs_vld && !id_ok) begin
        err_bad_id <= 1'b1;
      end
    end
  end

  assign mc_rq_vld    = rq_vld_reg;
  assign mc_rq_rtnctl = rq_rtnctl_reg;
  assign mc_rq_vadr   = rq_fields_reg.vadr;
  assign mc_rq_data   = rq_fields_reg.data;
  assign mc_rq_size   = rq_fields_reg.size;
  assign mc_rq_cmd    = rq_fields_reg.cmd;
  assign mc_rq_scmd   = rq_fields_reg.scmd;
  assign rs_vld       = rs_vld_reg;
  assign rs_cmd       = rs_cmd_reg;
  assign rs_scmd      = rs_scmd_reg;
  assign rs_data      = rs_data_reg;
  assign rs_rtnctl    = rs_tag_reg;
  assign mc_rs_stall  = mc_rs_stall_reg;
  assign port_idle    = port_idle_reg;

endmodule

// File: tb/tb_mc_port_arbiter.sv
module tb_mc_port_arbiter;
  localparam int N    = 4;
  localparam int RW   = 32;
  localparam int IDW  = 2;
  localparam int TW   = RW - IDW;
  localparam int MAXO = 4;

  logic            clk = 1'b0;
  logic            i_reset_n = 1'b0;
  logic [N-1:0]    req_vld = '0;
  logic [N-1:0]    req_rdy;
  logic [N*48-1:0] req_vadr;
  logic [N*64-1:0] req_data;
  logic [N*2-1:0]  req_size;
  logic [N*3-1:0]  req_cmd;
  logic [N*4-1:0]  req_scmd;
  logic [N*TW-1:0] req_rtnctl;
  logic [N-1:0]    rs_vld;
  logic [2:0]      rs_cmd;
  logic [3:0]      rs_scmd;
  logic [63:0]     rs_data;
  logic [TW-1:0]   rs_rtnctl;
  logic [N-1:0]    rs_stall = '0;
  logic            mc_rq_vld;
  logic [RW-1:0]   mc_rq_rtnctl;
  logic [63:0]     mc_rq_data;
  logic [47:0]     mc_rq_vadr;
  logic [1:0]      mc_rq_size;
  logic [2:0]      mc_rq_cmd;
  logic [3:0]      mc_rq_scmd;
  logic            mc_rq_stall = 1'b0;
  logic            mc_rs_vld = 1'b0;
  logic [2:0]      mc_rs_cmd = '0;
  logic [3:0]      mc_rs_scmd = '0;
  logic [63:0]     mc_rs_data = '0;
  logic [RW-1:0]   mc_rs_rtnctl = '0;
  logic            mc_rs_stall;
  logic            port_idle;

  logic [47:0] f_vadr [N];
  logic [63:0] f_data [N];
  logic [1:0]  f_size [N];
  logic [2:0]  f_cmd  [N];
  logic [3:0]  f_scmd [N];
  logic [TW-1:0] f_tag [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_vadr[i*48 +: 48]   = f_vadr[i];
      req_data[i*64 +: 64]   = f_data[i];
      req_size[i*2 +: 2]     = f_size[i];
      req_cmd[i*3 +: 3]      = f_cmd[i];
      req_scmd[i*4 +: 4]     = f_scmd[i];
      req_rtnctl[i*TW +: TW] = f_tag[i];
    end
  end

  mc_port_arbiter #(
    .NUM_REQ(N), .RTNCTL_WIDTH(RW), .ID_W(IDW), .MAX_OUT(MAXO), .CNT_W(3)
  ) dut (
    .clk(clk), .i_reset_n(i_reset_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_vadr(req_vadr), .req_data(req_data),
    .req_size(req_size), .req_cmd(req_cmd), .req_scmd(req_scmd), .req_rtnctl(req_rtnctl),
    .rs_vld(rs_vld), .rs_cmd(rs_cmd), .rs_scmd(rs_scmd), .rs_data(rs_data),
    .rs_rtnctl(rs_rtnctl), .rs_stall(rs_stall),
    .mc_rq_vld(mc_rq_vld), .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_data(mc_rq_data),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_cmd(mc_rq_cmd),
    .mc_rq_scmd(mc_rq_scmd), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_data(mc_rs_data), .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_stall(mc_rs_stall),
    .port_idle(port_idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard entries: what the DUT must present in cycle 'due'.
  typedef struct {
    int          due;
    logic [RW-1:0] rtnctl;
    logic [47:0] vadr;
    logic [63:0] data;
    logic [1:0]  size;
    logic [2:0]  cmd;
    logic [3:0]  scmd;
  } rq_exp_t;
  typedef struct {
    int          due;
    logic [N-1:0] vld;
    logic [2:0]  cmd;
    logic [3:0]  scmd;
    logic [63:0] data;
    logic [TW-1:0] tag;
  } rs_exp_t;
  rq_exp_t rq_q[$];
  rs_exp_t rs_q[$];

  // Reference model state: next requester in rotation, requests in flight,
  // whether a request was issued last cycle, and the last rs_stall OR.
  int   ptr_m = 0;
  int   cnt_m = 0;
  bit   last_g = 0;
  bit   prev_stall = 0;
  logic [N-1:0] seen_rdy;

  task automatic model_reset();
    ptr_m = 0; cnt_m = 0; last_g = 0; prev_stall = 0;
    rq_q.delete(); rs_q.delete();
  endtask

  task automatic model_eval();
    logic [N-1:0] exp_rdy;
    int win;
    seen_rdy = req_rdy;
    if (!i_reset_n) begin
      chk("rdy_in_reset", req_rdy, 0);
      chk("idle_in_reset", port_idle, 1);
      model_reset();
      return;
    end
    chk("port_idle", port_idle, (cnt_m == 0 && !last_g));
    chk("mc_rs_stall", mc_rs_stall, prev_stall);
    exp_rdy = '0;
    win = -1;
    if (!mc_rq_stall && cnt_m < MAXO) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && req_vld[(ptr_m + k) % N]) win = (ptr_m + k) % N;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_rdy", req_rdy, exp_rdy);
    if (win >= 0) begin
      rq_exp_t e;
      e.due = cyc + 1;
      e.rtnctl = {2'(win), f_tag[win]};
      e.vadr = f_vadr[win]; e.data = f_data[win]; e.size = f_size[win];
      e.cmd = f_cmd[win]; e.scmd = f_scmd[win];
      rq_q.push_back(e);
      ptr_m = (win + 1) % N;
    end
    if (mc_rs_vld) begin
      rs_exp_t r;
      r.due = cyc + 1;
      r.vld = '0;
      r.vld[mc_rs_rtnctl[RW-1 -: IDW]] = 1'b1;
      r.cmd = mc_rs_cmd; r.scmd = mc_rs_scmd; r.data = mc_rs_data;
      r.tag = mc_rs_rtnctl[TW-1:0];
      rs_q.push_back(r);
    end
    if (win >= 0 && !mc_rs_vld) cnt_m++;
    else if (win < 0 && mc_rs_vld && cnt_m > 0) cnt_m--;
    last_g = (win >= 0);
    prev_stall = |rs_stall;
  endtask

  // Inputs change at posedge+1, the model samples them at the negedge.
  task automatic tick();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rsp(input bit on);
    mc_rs_vld    = on;
    mc_rs_rtnctl = {2'($urandom_range(0, N - 1)), 30'($urandom)};
    mc_rs_data   = {$urandom, $urandom};
    mc_rs_cmd    = 3'($urandom);
    mc_rs_scmd   = 4'($urandom);
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      f_vadr[i] = {16'($urandom), $urandom};
      f_data[i] = {$urandom, $urandom};
      f_size[i] = 2'($urandom);
      f_cmd[i]  = 3'($urandom);
      f_scmd[i] = 4'($urandom);
      f_tag[i]  = 30'($urandom);
    end
  endtask

  // Monitor: pops the scoreboard whenever an entry falls due, otherwise the
  // corresponding valid must be low.
  always @(negedge clk) begin
    if (i_reset_n) begin
      if (rq_q.size() > 0 && rq_q[0].due == cyc) begin
        rq_exp_t e;
        e = rq_q.pop_front();
        chk("mc_rq", {mc_rq_vld, mc_rq_rtnctl, mc_rq_vadr, mc_rq_data, mc_rq_size, mc_rq_cmd, mc_rq_scmd},
            {1'b1, e.rtnctl, e.vadr, e.data, e.size, e.cmd, e.scmd});
      end else begin
        chk("mc_rq_vld_low", mc_rq_vld, 0);
      end
      if (rs_q.size() > 0 && rs_q[0].due == cyc) begin
        rs_exp_t r;
        r = rs_q.pop_front();
        chk("rs", {rs_vld, rs_cmd, rs_scmd, rs_data, rs_rtnctl}, {r.vld, r.cmd, r.scmd, r.data, r.tag});
      end else begin
        chk("rs_vld_low", rs_vld, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rand_fields();
    // Reset held: no grants even with all requests valid.
    @(posedge clk); #1;
    req_vld = 4'hF;
    tick(); tick();
    chk("rst_mc_rq", {mc_rq_vld, mc_rq_rtnctl, mc_rq_vadr, mc_rq_data}, 0);
    chk("rst_rs", {rs_vld, rs_rtnctl, rs_data, mc_rs_stall}, 0);
    #2 i_reset_n = 1'b1;

    // Fairness: 8 back-to-back grants in order 0,1,2,3,...
    for (int k = 0; k < 8; k++) begin
      rand_fields();
      drive_rsp(k > 0);
      tick();
      chk("fair_order", seen_rdy, 4'b0001 << (k % 4));
    end
    req_vld = '0; drive_rsp(1); tick(); drive_rsp(0);

    // Single request from requester 1.
    rand_fields();
    req_vld = 4'b0010; f_vadr[1] = 48'h1000; f_tag[1] = 30'h5;
    tick();
    req_vld = '0;
    chk("single_rdy", seen_rdy, 4'b0010);
    chk("single_vld", mc_rq_vld, 1);
    chk("single_vadr", mc_rq_vadr, 48'h1000);
    chk("single_rtnctl", mc_rq_rtnctl, 32'h4000_0005);
    chk("single_idle", port_idle, 0);

    // Response routing to requester 3.
    mc_rs_vld = 1'b1; mc_rs_rtnctl = 32'hC000_0009;
    tick();
    mc_rs_vld = 1'b0;
    chk("route_vld", rs_vld, 4'b1000);
    chk("route_rtnctl", rs_rtnctl, 30'h9);
    chk("route_idle", port_idle, 1);

    // Stall for cycles 3..5 under continuous requests.
    req_vld = 4'hF;
    for (int k = 0; k < 10; k++) begin
      mc_rq_stall = (k >= 3 && k <= 5);
      drive_rsp(cnt_m > 0);
      tick();
      if (k >= 3 && k <= 5) chk("stall_rdy", seen_rdy, 0);
    end
    mc_rq_stall = 1'b0;
    req_vld = '0; drive_rsp(cnt_m > 0); tick(); drive_rsp(0);

    // Outstanding limit.
    req_vld = 4'hF;
    for (int k = 0; k < 4; k++) tick();
    tick(); chk("limit_rdy", seen_rdy, 0);
    tick(); chk("limit_rdy", seen_rdy, 0);
    drive_rsp(1); tick(); chk("limit_rsp_rdy", seen_rdy, 0);
    drive_rsp(0); tick(); chk("limit_one_grant", $countones(seen_rdy), 1);
    tick(); chk("limit_full_again", seen_rdy, 0);

    // Bring outstanding to 3 with a request in the output register, then
    // reset asynchronously between edges.
    req_vld = '0;
    drive_rsp(1); tick(); drive_rsp(1); tick(); drive_rsp(0);
    req_vld = 4'hF; tick();
    chk("pre_reset_vld", mc_rq_vld, 1);
    #2 i_reset_n = 1'b0;
    #1;
    chk("async_rst_rq", {mc_rq_vld, mc_rq_rtnctl, mc_rq_vadr}, 0);
    chk("async_rst_idle", port_idle, 1);
    chk("async_rst_rs", {rs_vld, mc_rs_stall}, 0);
    chk("async_rst_rdy", req_rdy, 0);
    model_reset();
    @(posedge clk); #1;
    tick();
    #2 i_reset_n = 1'b1;
    tick();
    chk("post_reset_first", seen_rdy, 4'b0001);

    // Responses beyond the outstanding count: counter holds at zero.
    req_vld = '0;
    drive_rsp(1); tick(); drive_rsp(1); tick(); drive_rsp(0); tick();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) req_vld[i] = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 0) rand_fields();
      mc_rq_stall = ($urandom_range(0, 4) == 0);
      rs_stall = 4'($urandom);
      drive_rsp(cnt_m > 0 && $urandom_range(0, 2) != 0);
      tick();
    end

    // Drain.
    req_vld = '0; mc_rq_stall = 1'b0; rs_stall = '0;
    for (int c = 0; c < 20 && cnt_m > 0; c++) begin
      drive_rsp(1); tick();
    end
    drive_rsp(0);
    tick(); tick(); tick();
    chk("drain_cnt", cnt_m, 0);
    chk("scoreboard_empty", rq_q.size() + rs_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
